// File: rtl/csr_trap_seq.sv
// Trap-entry / MRET / CSR-instruction sequencer in front of a single-port CSR file.
// One request is serviced at a time, chosen in IDLE by priority trap > mret > ins.
module csr_trap_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_req,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_req,
    input  logic        ins_req,
    input  logic        ins_we,
    input  logic [11:0] ins_addr,
    input  logic [31:0] ins_wdata,
    output logic [31:0] ins_rdata,
    output logic        ins_ack,
    output logic        csr_write,
    output logic        csr_read,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_write_data,
    input  logic [31:0] csr_read_data,
    output logic        trap_done,
    output logic        mret_done,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    typedef enum logic [3:0] {
        IDLE, T_EPC, T_CAUSE, T_SRD, T_SWR, T_VEC,
        M_SRD, M_SWR, M_EPC, ACC, RESP
    } state_t;

    state_t      state, state_n;
    logic [31:0] epc_q;
    logic [31:0] cause_q;
    logic [31:0] ms_q;
    logic        trap_mode;
    logic [31:0] ms_trap;
    logic [31:0] ms_mret;

    // Trap: MPIE<=MIE, MIE<=0, MPP<=M.  MRET: MIE<=MPIE, MPIE<=1, MPP<=M.
    assign ms_trap = {ms_q[31:13], 2'b11, ms_q[10:8], ms_q[3], ms_q[6:4], 1'b0, ms_q[2:0]};
    assign ms_mret = {ms_q[31:13], 2'b11, ms_q[10:8], 1'b1, ms_q[6:4], ms_q[7], ms_q[2:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            epc_q       <= '0;
            cause_q     <= '0;
            ms_q        <= '0;
            trap_mode   <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                if (trap_req) begin
                    epc_q     <= trap_pc;
                    cause_q   <= trap_cause;
                    trap_mode <= 1'b1;
                end else if (mret_req) begin
                    trap_mode <= 1'b0;
                end
            end
            if (state == T_SRD || state == M_SRD) begin
                ms_q <= csr_read_data;
            end
            if (state == T_VEC || state == M_EPC) begin
                redirect_pc <= csr_read_data & 32'hFFFF_FFFC;
            end
        end
    end

    always_comb begin
        state_n        = state;
        csr_write      = 1'b0;
        csr_read       = 1'b0;
        csr_addr       = '0;
        csr_write_data = '0;
        ins_rdata      = '0;
        ins_ack        = 1'b0;
        trap_done      = 1'b0;
        mret_done      = 1'b0;
        busy           = (state != IDLE);

        case (state)
            IDLE: begin
                if (trap_req) begin
                    state_n = T_EPC;
                end else if (mret_req) begin
                    state_n = M_SRD;
                end else if (ins_req) begin
                    state_n = ACC;
                end
            end
            T_EPC: begin
                csr_write      = 1'b1;
                csr_addr       = ADDR_MEPC;
                csr_write_data = epc_q & 32'hFFFF_FFFC;
                state_n        = T_CAUSE;
            end
            T_CAUSE: begin
                csr_write      = 1'b1;
                csr_addr       = ADDR_MCAUSE;
                csr_write_data = cause_q;
                state_n        = T_SRD;
            end
            T_SRD: begin
                csr_read = 1'b1;
                csr_addr = ADDR_MSTATUS;
                state_n  = T_SWR;
            end
            T_SWR: begin
                csr_write      = 1'b1;
                csr_addr       = ADDR_MSTATUS;
                csr_write_data = ms_trap;
                state_n        = T_VEC;
            end
            T_VEC: begin
                csr_read = 1'b1;
                csr_addr = ADDR_MTVEC;
                state_n  = RESP;
            end
            M_SRD: begin
                csr_read = 1'b1;
                csr_addr = ADDR_MSTATUS;
                state_n  = M_SWR;
            end
            M_SWR: begin
                csr_write      = 1'b1;
                csr_addr       = ADDR_MSTATUS;
                csr_write_data = ms_mret;
                state_n        = M_EPC;
            end
            M_EPC: begin
                csr_read = 1'b1;
                csr_addr = ADDR_MEPC;
                state_n  = RESP;
            end
            // Read and write share the cycle; the CSR file returns the pre-write value.
            ACC: begin
                csr_read       = 1'b1;
                csr_write      = ins_we;
                csr_addr       = ins_addr;
                csr_write_data = ins_wdata;
                ins_rdata      = csr_read_data;
                ins_ack        = 1'b1;
                state_n        = IDLE;
            end
            RESP: begin
                trap_done = trap_mode;
                mret_done = !trap_mode;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/csr_trap_seq.md
CSR_TRAP_SEQ -- requirements
Module: csr_trap_seq

Interface
REQ-001 SHALL have no parameters; widths fixed: data 32, CSR address 12.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have the following ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- trap_req  input  1  trap request, level, held until trap_done
- trap_pc  input  32  PC of trapping instruction
- trap_cause  input  32  mcause value
- mret_req  input  1  MRET request, level, held until mret_done
- ins_req  input  1  CSR-instruction access request, held until ins_ack
- ins_we  input  1  instruction access writes
- ins_addr  input  12  instruction CSR address
- ins_wdata  input  32  instruction write data
- ins_rdata  output  32  instruction read data, valid while ins_ack=1
- ins_ack  output  1  one-cycle access acknowledge
- csr_write  output  1  CSR-file write enable
- csr_read  output  1  CSR-file read enable
- csr_addr  output  12  CSR-file address
- csr_write_data  output  32  CSR-file write data
- csr_read_data  input  32  CSR-file read data, combinational from csr_addr/csr_read
- trap_done  output  1  one-cycle pulse, trap entry complete
- mret_done  output  1  one-cycle pulse, MRET complete
- redirect_pc  output  32  fetch target, registered, held until next done
- busy  output  1  high whenever state is not IDLE

Function
REQ-004 SHALL implement the FSM states IDLE, T_EPC, T_CAUSE, T_SRD, T_SWR, T_VEC, M_SRD, M_SWR, M_EPC, ACC, and RESP.
REQ-005 SHALL accept requests only in IDLE, with fixed priority trap_req > mret_req > ins_req; requests arriving while busy SHALL wait.
REQ-006 SHALL, on trap acceptance, latch trap_pc and trap_cause; later changes to these inputs SHALL be ignored.
REQ-007 SHALL sequence a trap as follows:
- T_EPC: write 0x341 with {trap_pc[31:2],2'b00}
- T_CAUSE: write 0x342 with trap_cause
- T_SRD: read 0x300 and latch it as ms
- T_SWR: write 0x300 with ms, MPIE(bit7)=ms[3], MIE(bit3)=0, MPP[12:11]=2'b11
- T_VEC: read 0x305; redirect_pc <= {data[31:2],2'b00}
- RESP: trap_done=1
REQ-008 SHALL sequence an MRET as follows:
- M_SRD: read 0x300 and latch it as ms
- M_SWR: write 0x300 with ms, MIE=ms[7], MPIE=1, MPP=2'b11
- M_EPC: read 0x341; redirect_pc <= {data[31:2],2'b00}
- RESP: mret_done=1
REQ-009 SHALL assert trap_done exactly 6 cycles after the acceptance edge and mret_done exactly 4 cycles after it; RESP SHALL then return to IDLE.
REQ-010 SHALL perform an instruction access in the single ACC state, entered one edge after acceptance:
- csr_read=1, csr_write=ins_we, csr_addr=ins_addr, csr_write_data=ins_wdata
- ins_rdata=csr_read_data, returning the pre-write value
- ins_ack=1
- next state IDLE
REQ-011 SHALL, in every state other than ACC and the CSR-access states of REQ-007/REQ-008, drive csr_write=0, csr_read=0, csr_addr=0, and csr_write_data=0.
REQ-012 SHALL never assert csr_write and csr_read together, except in ACC.
REQ-013 SHALL treat a trap_req that rises in the same cycle as an ACC or RESP state as pending and accept it in the next IDLE cycle.
REQ-014 SHALL not filter csr_addr by validity; unimplemented addresses are passed through as-is.

Reset
REQ-015 SHALL, while rst=0, asynchronously force:
- state=IDLE
- busy, ins_ack, trap_done, mret_done, csr_write, csr_read = 0
- csr_addr, csr_write_data, ins_rdata, redirect_pc, and latched registers = 0
REQ-016 SHALL abandon any in-flight sequence on reset mid-operation, issue no further CSR writes, and resume from IDLE after release.

Verification
REQ-017 SHALL pass a trap scenario: mstatus=0x00000008, mtvec=0x00000101; assert trap_req, trap_pc=0x00000204, trap_cause=0x0000000B -> mepc=0x00000204, mcause=0x0000000B, mstatus=0x00001880, redirect_pc=0x00000100, trap_done on the 6th cycle.
REQ-018 SHALL pass an MRET scenario: mstatus=0x00001880, mepc=0x00000208; assert mret_req -> mstatus=0x00001888, redirect_pc=0x00000208, mret_done on the 4th cycle.
REQ-019 SHALL pass a simultaneous-request scenario: trap_req, mret_req, and ins_req asserted in the same cycle -> trap runs first, then MRET, then ACC; order is confirmed by the done/ack pulse sequence.
REQ-020 SHALL pass an instruction-access scenario: ins_we=1, ins_addr=0x340, ins_wdata=0xDEADBEEF with old value 0x12345678 -> ins_rdata=0x12345678 with ins_ack for one cycle; 0x340 reads 0xDEADBEEF afterwards.
REQ-021 SHALL pass a reset-mid-trap scenario: rst=0 in T_CAUSE -> outputs zero immediately, mstatus unchanged, trap_done never pulses; after release a held trap_req restarts from T_EPC.
REQ-022 SHALL pass a busy-hold scenario: ins_req asserted during an MRET -> ins_ack exactly one cycle after mret_done's RESP returns to IDLE plus one acceptance edge; busy is high throughout.
